cmd_bus_master: RTL and testbench
=================================

# cmd_bus_master

Byte-stream command bridge that turns host command frames (from the UART receiver stream) into single 32-bit bus read/write transactions. It drives the master side of the address-decoding interconnect and returns status and read data as a byte stream to the UART transmitter. It is the only bus master in the control path, so exactly one transaction is outstanding at any time.

## Interface
- TIMEOUT_CYCLES, 1024: consecutive waitrequest-high cycles before a transaction is aborted (used only with the timeout feature compiled in).
- TIMEOUT_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx_data  in  8  command byte from the host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- tx_data  out  8  response byte to the host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  byte consumed when tx_valid && tx_ready.
- bus_addr  out  32  transaction address.
- bus_read  out  1  read request.
- bus_write  out  1  write request.
- bus_writedata  out  32  write data.
- bus_byteenable  out  4  always 4'hF.
- bus_readdata  in  32  read data, valid in the cycle the read completes.
- bus_response  in  2  response code, sampled in the completing cycle.
- bus_waitrequest  in  1  slave stall.
- busy  out  1  high in every state except IDLE.

## Operation
- Frame format. Opcode byte, then 4 address bytes MSB first, then for writes only 4 data bytes MSB first. 0x01 is write; 0x02 is read.
- Response for a write: 1 status byte.
- Response for a read: 1 status byte, then 4 data bytes MSB first.
- Status byte: {timeout, 5'b0, bus_response}.
- FSM states: IDLE, ADDR, WDATA, BUS, RESP.
- IDLE: rx_ready=1. On 0x01 or 0x02, latch the opcode and go to ADDR. On any other opcode, load the single response byte 0xEE and go to RESP.
- ADDR: rx_ready=1. A 2-bit byte counter shifts each byte into bus_addr. After the 4th byte, go to WDATA for a write or BUS for a read.
- WDATA: rx_ready=1. Bytes shift into bus_writedata. After the 4th byte, go to BUS.
- BUS: rx_ready=0. bus_read or bus_write is high, registered. Completion is the first rising edge with bus_waitrequest=0. On completion:
  - capture bus_readdata and bus_response;
  - drop the request in the next cycle;
  - go to RESP.
- RESP: shift out the response bytes through tx_*, then return to IDLE.
- Outputs are registered and hold their values between transactions; only bus_read and bus_write return to 0.

## Timing
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, bus_addr=0, bus_writedata=0, bus_read=0, bus_write=0, bus_byteenable=4'hF, busy=0. State = IDLE, counters = 0.
- rx_ready rises in the first cycle after reset release.
- The request asserts in the cycle after the last frame byte is accepted.
- The minimum bus phase is 1 cycle (waitrequest low immediately).
- tx_valid asserts in the cycle after completion.
- tx_data/tx_valid must stay stable until tx_ready. Back-to-back bytes are allowed, one per cycle when tx_ready=1.
- Return to IDLE: IDLE (rx_ready=1) is entered in the cycle after the last response byte is consumed.
- The bus request is held constant (address, data, strobes) while waitrequest=1.
- rx_valid while rx_ready=0 is ignored; the byte is not consumed.
- rst_n low at any point aborts immediately:
  - requests drop asynchronously;
  - a partial frame or response is discarded;
  - no status byte is emitted.

## Configuration
- CMD_BUS_TIMEOUT_EN defined:
  - A TIMEOUT_W counter clears on entry to BUS and increments each cycle that bus_waitrequest=1.
  - When it reaches TIMEOUT_CYCLES with waitrequest still high, the request drops in the next cycle.
  - Status = 0x80. Read data bytes are returned as 0x00.
  - Completion and timeout in the same cycle count as completion.
- CMD_BUS_TIMEOUT_EN undefined: no counter. BUS waits indefinitely, and status bit 7 is always 0.

## Test plan
- Write: rx 01 00 00 01 04 DE AD BE EF. Required:
  - bus_write high exactly 1 cycle with addr 0x00000104, data 0xDEADBEEF, be 4'hF;
  - tx 0x00.
- Read with stall: rx 02 00 00 02 00, waitrequest high 3 cycles, readdata 0x12345678, response 2'b10 at completion. Required:
  - bus_read high 4 cycles, addr stable throughout;
  - tx 02 12 34 56 78.
- Bad opcode: rx 0x7F. Required: tx 0xEE, back in IDLE, a following valid write frame executes normally.
- Backpressure: read response with tx_ready toggling 1/0 each cycle. Required: 5 bytes delivered in order, each tx_data stable while tx_valid && !tx_ready.
- Timeout (CMD_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): read with waitrequest stuck high. Required: request drops after 16 stall cycles, tx 80 00 00 00 00. Without the macro, the request stays high for 100+ cycles.
- Reset mid-frame: rst_n low after 2 address bytes. Required:
  - all outputs at reset values;
  - a fresh full write frame after release executes with the correct address.

Source files
------------

// File: rtl/cmd_bus_if.sv
// cmd_bus_if -- single-master 32-bit bus between cmd_bus_master and the
// address-decoding interconnect.
//   master: drives bus_addr/bus_read/bus_write/bus_writedata/bus_byteenable,
//           samples bus_readdata/bus_response/bus_waitrequest.
//   slave : the mirror image.
interface cmd_bus_if;
  logic [31:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_readdata;
  logic [1:0]  bus_response;
  logic        bus_waitrequest;

  modport master (
    output bus_addr, bus_read, bus_write, bus_writedata, bus_byteenable,
    input  bus_readdata, bus_response, bus_waitrequest
  );

  modport slave (
    input  bus_addr, bus_read, bus_write, bus_writedata, bus_byteenable,
    output bus_readdata, bus_response, bus_waitrequest
  );
endinterface

// File: rtl/cmd_bus_master.sv
// cmd_bus_master -- turns host byte-stream command frames into single 32-bit
// bus transactions and streams the status/read data back.
//   Frame : opcode (0x01 write, 0x02 read), 4 address bytes MSB first,
//           then 4 data bytes MSB first for writes.
//   Reply : status {timeout,5'b0,response}; reads add 4 data bytes MSB first.
//           Unknown opcodes reply with the single byte 0xEE.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rx_data/valid/ready   command byte stream in
//   tx_data/valid/ready   response byte stream out
//   bus                   cmd_bus_if.master towards the interconnect
//   busy                  high whenever the FSM is not in IDLE
// Optional feature: define CMD_BUS_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES consecutive waitrequest cycles (status 0x80, data 0x00).
module cmd_bus_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  cmd_bus_if.master   bus,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  state_t      state_q;
  logic        is_wr_q;
  logic [1:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  tx_left_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q, rx_ready_q, rd_q, wr_q, busy_q;
`ifdef CMD_BUS_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
`endif

  logic rx_acc;
  assign rx_acc = rx_valid && rx_ready_q;

  assign rx_ready            = rx_ready_q;
  assign tx_data             = tx_data_q;
  assign tx_valid            = tx_valid_q;
  assign busy                = busy_q;
  assign bus.bus_addr        = addr_q;
  assign bus.bus_writedata   = wdata_q;
  assign bus.bus_read        = rd_q;
  assign bus.bus_write       = wr_q;
  assign bus.bus_byteenable  = 4'hF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tx_left_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
`ifdef CMD_BUS_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_acc) begin
            busy_q <= 1'b1;
            if (rx_data == 8'h01 || rx_data == 8'h02) begin
              is_wr_q <= (rx_data == 8'h01);
              cnt_q   <= '0;
              state_q <= ADDR;
            end else begin
              tx_data_q  <= 8'hEE;
              tx_valid_q <= 1'b1;
              tx_left_q  <= '0;
              rx_ready_q <= 1'b0;
              state_q    <= RESP;
            end
          end
        end
        ADDR: if (rx_acc) begin
          addr_q <= {addr_q[23:0], rx_data};
          cnt_q  <= cnt_q + 2'd1;       // wraps to 0, ready for WDATA
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_q <= WDATA;
            end else begin
              state_q    <= BUS;
              rx_ready_q <= 1'b0;
              rd_q       <= 1'b1;
`ifdef CMD_BUS_TIMEOUT_EN
              tmo_cnt_q  <= '0;
`endif
            end
          end
        end
        WDATA: if (rx_acc) begin
          wdata_q <= {wdata_q[23:0], rx_data};
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q    <= BUS;
            rx_ready_q <= 1'b0;
            wr_q       <= 1'b1;
`ifdef CMD_BUS_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
          end
        end
        BUS: begin
          // Completion wins over a timeout landing in the same cycle.
          if (!bus.bus_waitrequest) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rdata_q    <= bus.bus_readdata;
            tx_data_q  <= {6'b0, bus.bus_response};
            tx_valid_q <= 1'b1;
            tx_left_q  <= rd_q ? 3'd4 : 3'd0;
            state_q    <= RESP;
          end
`ifdef CMD_BUS_TIMEOUT_EN
          // Count reaching TIMEOUT_CYCLES-1 here means this is the
          // TIMEOUT_CYCLES-th stalled cycle: give up.
          else if (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rdata_q    <= '0;
            tx_data_q  <= 8'h80;
            tx_valid_q <= 1'b1;
            tx_left_q  <= rd_q ? 3'd4 : 3'd0;
            state_q    <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        RESP: if (tx_ready) begin
          if (tx_left_q != 3'd0) begin
            tx_data_q <= rdata_q[31:24];
            rdata_q   <= {rdata_q[23:0], 8'h00};
            tx_left_q <= tx_left_q - 3'd1;
          end else begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_bus_master.sv
module tb_cmd_bus_master;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  always #5 clk = ~clk;

  cmd_bus_if bif();

  cmd_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus(bif), .busy(busy)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus slave model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          we;
    int          cycles;
  } txn_t;

  txn_t        txq[$];
  txn_t        cur;
  bit          in_txn = 0;
  int          stalls = 0;
  int          cfg_stall = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_resp = '0;

  initial begin
    bif.bus_waitrequest = 1'b0;
    bif.bus_readdata    = '0;
    bif.bus_response    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 0;
        bif.bus_waitrequest = 1'b0;
      end else if (bif.bus_read || bif.bus_write) begin
        if (!in_txn) begin
          in_txn     = 1;
          cur.addr   = bif.bus_addr;
          cur.data   = bif.bus_writedata;
          cur.we     = bif.bus_write;
          cur.cycles = 0;
          stalls     = cfg_stall;
        end else begin
          chk("addr_stable", bif.bus_addr, cur.addr);
          chk("wdata_stable", bif.bus_writedata, cur.data);
          chk("we_stable", bif.bus_write, cur.we);
        end
        chk("rd_wr_excl", bif.bus_read & bif.bus_write, 0);
        chk("byteenable", bif.bus_byteenable, 4'hF);
        chk("busy_in_bus", busy, 1);
        chk("rx_ready_in_bus", rx_ready, 0);
        cur.cycles++;
        // Bogus data while stalled so an early capture shows up.
        if (stalls > 0) begin
          bif.bus_waitrequest = 1'b1;
          bif.bus_readdata    = ~cfg_rdata;
          bif.bus_response    = ~cfg_resp;
          stalls--;
        end else begin
          bif.bus_waitrequest = 1'b0;
          bif.bus_readdata    = cfg_rdata;
          bif.bus_response    = cfg_resp;
        end
      end else begin
        if (in_txn) begin
          txq.push_back(cur);
          in_txn = 0;
        end
        bif.bus_waitrequest = 1'b0;
        bif.bus_readdata    = ~cfg_rdata;
      end
    end
  end

  // ---------------- tx sink ----------------
  logic [7:0] rxq[$];
  int         tx_mode = 0;   // 0 always ready, 1 toggle, 2 random
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  bit         tog = 0;

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_ready   = 1'b0;
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("tx_valid_hold", tx_valid, 1);
          chk("tx_data_hold", tx_data, prev_data);
        end
        case (tx_mode)
          0:       tx_ready = 1'b1;
          1:       begin tog = ~tog; tx_ready = tog; end
          default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        if (tx_valid && tx_ready) rxq.push_back(tx_data);
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  // ---------------- vectors and reference model ----------------
  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          mode;
    int          exp_n;
    logic [39:0] exp_w;      // first response byte in [39:32]
    int          exp_cycles; // 0 = no bus transaction expected
  } vec_t;

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input int stall,
                              input logic [31:0] rdata, input logic [1:0] resp,
                              input int mode, input int exp_n,
                              input logic [39:0] exp_w, input int exp_cycles);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.stall = stall;
    v.rdata = rdata; v.resp = resp; v.mode = mode;
    v.exp_n = exp_n; v.exp_w = exp_w; v.exp_cycles = exp_cycles;
    return v;
  endfunction

  // Expected reply from the frame rules: status byte, read data, or 0xEE.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.op == 8'h01) begin
      r.exp_n = 1; r.exp_w = {6'b0, v.resp, 32'h0}; r.exp_cycles = v.stall + 1;
    end else if (v.op == 8'h02) begin
      r.exp_n = 5; r.exp_w = {6'b0, v.resp, v.rdata}; r.exp_cycles = v.stall + 1;
    end else begin
      r.exp_n = 1; r.exp_w = {8'hEE, 32'h0}; r.exp_cycles = 0;
    end
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] bytes[$]);
    int t;
    @(negedge clk);
    foreach (bytes[i]) begin
      rx_data  = bytes[i];
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) chk("rx_accept_bound", 0, 1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  function automatic void build(input vec_t v, output logic [7:0] q[$]);
    q = {v.op};
    if (v.op == 8'h01 || v.op == 8'h02)
      q = {q, v.addr[31:24], v.addr[23:16], v.addr[15:8], v.addr[7:0]};
    if (v.op == 8'h01)
      q = {q, v.wdata[31:24], v.wdata[23:16], v.wdata[15:8], v.wdata[7:0]};
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic [7:0] q[$];
    int t;
    cfg_stall = v.stall; cfg_rdata = v.rdata; cfg_resp = v.resp;
    tx_mode = v.mode;
    rxq.delete(); txq.delete();
    build(v, q);
    send_frame(q);
    // Junk byte offered while rx_ready is low must not be consumed.
    rx_data = 8'hA5; rx_valid = 1'b1;
    t = 0;
    while (!tx_valid && t < 300) begin @(negedge clk); t++; end
    rx_valid = 1'b0;
    if (t >= 300) chk({tag, "_tx_valid_bound"}, 0, 1);
    t = 0;
    while (rxq.size() < v.exp_n && t < 300) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk({tag, "_nbytes"}, rxq.size(), v.exp_n);
    for (int i = 0; i < v.exp_n && i < rxq.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rxq[i], v.exp_w[39 - 8*i -: 8]);
    chk({tag, "_ntxn"}, txq.size(), (v.exp_cycles != 0) ? 1 : 0);
    if (v.exp_cycles != 0 && txq.size() > 0) begin
      chk({tag, "_addr"}, txq[0].addr, v.addr);
      chk({tag, "_we"}, txq[0].we, v.op == 8'h01);
      if (v.op == 8'h01) chk({tag, "_wdata"}, txq[0].data, v.wdata);
      chk({tag, "_cycles"}, txq[0].cycles, v.exp_cycles);
    end
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rx_ready"}, rx_ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_addr"}, bif.bus_addr, 0);
    chk({tag, "_wdata"}, bif.bus_writedata, 0);
    chk({tag, "_read"}, bif.bus_read, 0);
    chk({tag, "_write"}, bif.bus_write, 0);
    chk({tag, "_be"}, bif.bus_byteenable, 4'hF);
    chk({tag, "_busy"}, busy, 0);
  endtask

  vec_t tbl[5];
  vec_t v;
  logic [7:0] q[$];

  initial begin
    tbl[0] = mk(8'h01, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0,         2'd0, 0, 1, 40'h00_0000_0000, 1);
    tbl[1] = mk(8'h02, 32'h0000_0200, 32'h0,         3, 32'h1234_5678, 2'd2, 0, 5, 40'h02_1234_5678, 4);
    tbl[2] = mk(8'h7F, 32'h0,         32'h0,         0, 32'h0,         2'd0, 0, 1, 40'hEE_0000_0000, 0);
    tbl[3] = mk(8'h01, 32'h0000_00A0, 32'h0000_0001, 2, 32'h0,         2'd1, 0, 1, 40'h01_0000_0000, 3);
    tbl[4] = mk(8'h02, 32'h0000_0010, 32'h0,         1, 32'hCAFE_F00D, 2'd3, 1, 5, 40'h03_CAFE_F00D, 2);

    #2 check_reset_vals("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("por_rel_rx_ready_low", rx_ready, 0);
    @(negedge clk);
    chk("por_rel_rx_ready_high", rx_ready, 1);

    for (int i = 0; i < 5; i++) apply(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      v.op    = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom_range(3, 255));
      v.addr  = $urandom; v.wdata = $urandom; v.rdata = $urandom;
      v.resp  = 2'($urandom_range(0, 3));
      v.stall = $urandom_range(0, 4);
      v.mode  = $urandom_range(0, 2);
      apply(model(v), $sformatf("rnd%0d", i));
    end

`ifdef CMD_BUS_TIMEOUT_EN
    apply(mk(8'h02, 32'h0000_0300, 32'h0, 1000, 32'hFFFF_FFFF, 2'd1, 0,
             5, 40'h80_0000_0000, 16), "timeout");
`else
    cfg_stall = 1000; tx_mode = 0; txq.delete(); rxq.delete();
    v = mk(8'h02, 32'h0000_0300, 32'h0, 1000, 32'h0, 2'd0, 0, 0, 40'h0, 0);
    build(v, q);
    send_frame(q);
    repeat (120) @(negedge clk);
    chk("no_timeout_read_held", bif.bus_read, 1);
    chk("no_timeout_no_tx", tx_valid, 0);
    rst_n = 1'b0;
    #1 chk("no_timeout_async_drop", bif.bus_read, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // Reset in the middle of a frame, then a full frame must run cleanly.
    cfg_stall = 0;
    send_frame('{8'h01, 8'h12, 8'h34});
    rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rx_ready_high", rx_ready, 1);
    apply(mk(8'h01, 32'h0000_0ABC, 32'h55AA_55AA, 1, 32'h0, 2'd2, 2,
             1, 40'h02_0000_0000, 2), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
